// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split and cache FSM encoding.
package cpu_types_pkg;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBYT_W = 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath and memory-controller signals seen by the instruction cache.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped 16-frame, one-word-per-frame read-only instruction cache.
// Latency: hit same cycle; miss returns (iwait-high cycles + 2) later.
// Backpressure: stalls the datapath (ihit low) while the controller holds iwait.
module icache
    import cpu_types_pkg::*;
(
    input logic     CLK,
    input logic     nRST,
    icache_if.slave bus
);

    localparam int NFRAMES = 1 << IIDX_W;

    icache_state_t                      state;
    icache_state_t                      next_state;
    logic [31:0]                        missaddr;
    logic [NFRAMES-1:0]                 valid_q;
    logic [NFRAMES-1:0][ITAG_W-1:0]     tag_q;
    logic [NFRAMES-1:0][31:0]           data_q;

    icachef_t    req_f;
    icachef_t    miss_f;
    logic        lookup_hit;
    logic        hit;
    logic        latch_miss;
    logic        fill;
    logic        iren_c;
    logic [31:0] iaddr_c;

    assign req_f      = icachef_t'(bus.imemaddr);
    assign miss_f     = icachef_t'(missaddr);
    assign lookup_hit = valid_q[req_f.idx] && (tag_q[req_f.idx] == req_f.tag);

    // Byte offsets play no part in a word-granular cache.
    logic unused_bytoff;
    assign unused_bytoff = ^{req_f.bytoff, miss_f.bytoff};

    always_comb begin
        next_state = state;
        hit        = 1'b0;
        latch_miss = 1'b0;
        fill       = 1'b0;
        iren_c     = 1'b0;
        iaddr_c    = 32'h0;
        case (state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (lookup_hit) begin
                        hit = 1'b1;
                    end else begin
                        latch_miss = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                // The request is held to missaddr regardless of what the datapath does now.
                iren_c  = 1'b1;
                iaddr_c = missaddr;
                if (!bus.iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the state register clears.
    assign bus.ihit     = hit & nRST;
    assign bus.imemload = (hit && nRST) ? data_q[req_f.idx] : 32'h0;
    assign bus.iREN     = iren_c & nRST;
    assign bus.iaddr    = nRST ? iaddr_c : 32'h0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            missaddr <= 32'h0;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state <= next_state;
            if (latch_miss) begin
                missaddr <= {bus.imemaddr[31:2], 2'b00};
            end
            if (fill) begin
                valid_q[miss_f.idx] <= 1'b1;
                tag_q[miss_f.idx]   <= miss_f.tag;
                data_q[miss_f.idx]  <= bus.iload;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: reset, miss/fill timing, hits, conflicts, mid-fetch events.
module tb_icache;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;
    int   lat;
    int   cnt;
    logic [31:0] ia;

    icache_if bus ();

    icache dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request and plays a memory controller that holds iwait for nwait
    // FETCH cycles; returns cycles until ihit, iREN-high cycles and last iaddr seen.
    task automatic run_miss(input logic [31:0] a, input logic [31:0] d, input int nwait,
                            output int l, output int c, output logic [31:0] seen);
        @(posedge clk); #1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        bus.iload    = d;
        bus.iwait    = 1'b1;
        l = 0; c = 0; seen = 32'h0;
        @(negedge clk);
        while (!bus.ihit && l < 50) begin
            if (bus.iREN) begin
                c++;
                seen = bus.iaddr;
            end
            @(posedge clk); #1;
            l++;
            bus.iwait = (c < nwait) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus.iwait = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iwait = 1'b1; bus.iload = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++; if (bus.ihit !== 1'b0) begin fails++; $display("FAIL reset_ihit got=%b exp=0", bus.ihit); end
        tests++; if (bus.iREN !== 1'b0) begin fails++; $display("FAIL reset_iren got=%b exp=0", bus.iREN); end
        tests++; if (bus.iaddr !== 32'h0) begin fails++; $display("FAIL reset_iaddr got=%h exp=0", bus.iaddr); end
        tests++; if (bus.imemload !== 32'h0) begin fails++; $display("FAIL reset_imemload got=%h exp=0", bus.imemload); end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        tests++; if (bus.ihit !== 1'b0) begin fails++; $display("FAIL post_reset_ihit got=%b exp=0", bus.ihit); end
        tests++; if (bus.iREN !== 1'b0) begin fails++; $display("FAIL post_reset_iren got=%b exp=0", bus.iREN); end
        tests++; if (bus.iaddr !== 32'h0) begin fails++; $display("FAIL post_reset_iaddr got=%h exp=0", bus.iaddr); end
        tests++; if (bus.imemload !== 32'h0) begin fails++; $display("FAIL post_reset_imemload got=%h exp=0", bus.imemload); end
    endtask

    task automatic test_miss_fill();
        run_miss(32'h40, 32'h2001_0005, 3, lat, cnt, ia);
        tests++; if (lat !== 5) begin fails++; $display("FAIL miss_latency got=%0d exp=5", lat); end
        tests++; if (cnt !== 4) begin fails++; $display("FAIL miss_iren_cycles got=%0d exp=4", cnt); end
        tests++; if (ia !== 32'h40) begin fails++; $display("FAIL miss_iaddr got=%h exp=00000040", ia); end
        tests++; if (bus.imemload !== 32'h2001_0005) begin fails++; $display("FAIL miss_imemload got=%h exp=20010005", bus.imemload); end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
            @(negedge clk);
            tests++; if (bus.ihit !== 1'b1) begin fails++; $display("FAIL hit_ihit got=%b exp=1", bus.ihit); end
            tests++; if (bus.iREN !== 1'b0) begin fails++; $display("FAIL hit_iren got=%b exp=0", bus.iREN); end
            tests++; if (bus.imemload !== 32'h2001_0005) begin fails++; $display("FAIL hit_imemload got=%h exp=20010005", bus.imemload); end
        end
        @(posedge clk); #1;
        bus.imemREN = 1'b0;
        @(negedge clk);
        tests++; if (bus.ihit !== 1'b0) begin fails++; $display("FAIL idle_ihit got=%b exp=0", bus.ihit); end
    endtask

    task automatic test_conflict();
        run_miss(32'h80, 32'h1111_0080, 2, lat, cnt, ia);
        tests++; if (lat !== 4) begin fails++; $display("FAIL conflict_0x80_latency got=%0d exp=4", lat); end
        tests++; if (ia !== 32'h80) begin fails++; $display("FAIL conflict_0x80_iaddr got=%h exp=00000080", ia); end
        tests++; if (bus.imemload !== 32'h1111_0080) begin fails++; $display("FAIL conflict_0x80_data got=%h exp=11110080", bus.imemload); end
        run_miss(32'h40, 32'h2222_0040, 1, lat, cnt, ia);
        tests++; if (lat !== 3) begin fails++; $display("FAIL conflict_0x40_latency got=%0d exp=3", lat); end
        tests++; if (bus.imemload !== 32'h2222_0040) begin fails++; $display("FAIL conflict_0x40_data got=%h exp=22220040", bus.imemload); end
    endtask

    task automatic test_midfetch_addr_change();
        @(posedge clk); #1;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h44; bus.iwait = 1'b1; bus.iload = 32'hCAFE_0044;
        @(posedge clk); #1;
        bus.imemaddr = 32'h100; bus.imemREN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h44) begin
                fails++; $display("FAIL midfetch_hold iren=%b iaddr=%h exp iren=1 iaddr=00000044", bus.iREN, bus.iaddr);
            end
            @(posedge clk); #1;
        end
        bus.iwait = 1'b0;
        @(negedge clk);
        tests++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h44) begin
            fails++; $display("FAIL midfetch_fill iren=%b iaddr=%h exp iren=1 iaddr=00000044", bus.iREN, bus.iaddr);
        end
        @(posedge clk); #1;
        bus.iwait = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h44;
        @(negedge clk);
        tests++; if (bus.ihit !== 1'b1) begin fails++; $display("FAIL midfetch_0x44_hit got=%b exp=1", bus.ihit); end
        tests++; if (bus.imemload !== 32'hCAFE_0044) begin fails++; $display("FAIL midfetch_0x44_data got=%h exp=cafe0044", bus.imemload); end
        run_miss(32'h100, 32'h5555_0100, 1, lat, cnt, ia);
        tests++; if (lat !== 3) begin fails++; $display("FAIL midfetch_0x100_latency got=%0d exp=3", lat); end
        tests++; if (ia !== 32'h100) begin fails++; $display("FAIL midfetch_0x100_iaddr got=%h exp=00000100", ia); end
    endtask

    task automatic test_reset_midfetch();
        @(posedge clk); #1;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h2000; bus.iwait = 1'b1; bus.iload = 32'hDEAD_2000;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (bus.iREN !== 1'b1) begin fails++; $display("FAIL rstfetch_pre_iren got=%b exp=1", bus.iREN); end
        @(posedge clk); #1;
        nrst = 1'b0; bus.imemREN = 1'b0;
        @(negedge clk);
        tests++; if (bus.iREN !== 1'b0) begin fails++; $display("FAIL rstfetch_during_iren got=%b exp=0", bus.iREN); end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        tests++; if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
            fails++; $display("FAIL rstfetch_after iren=%b iaddr=%h exp iren=0 iaddr=0", bus.iREN, bus.iaddr);
        end
        run_miss(32'h44, 32'h3333_0044, 0, lat, cnt, ia);
        tests++; if (lat !== 2) begin fails++; $display("FAIL rstfetch_0x44_latency got=%0d exp=2", lat); end
        tests++; if (bus.imemload !== 32'h3333_0044) begin fails++; $display("FAIL rstfetch_0x44_data got=%h exp=33330044", bus.imemload); end
    endtask

    task automatic test_unaligned();
        run_miss(32'h43, 32'h4444_0040, 1, lat, cnt, ia);
        tests++; if (ia !== 32'h40) begin fails++; $display("FAIL unaligned_iaddr got=%h exp=00000040", ia); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL unaligned_latency got=%0d exp=3", lat); end
        @(posedge clk); #1;
        bus.imemaddr = 32'h40;
        @(negedge clk);
        tests++; if (bus.ihit !== 1'b1) begin fails++; $display("FAIL unaligned_0x40_hit got=%b exp=1", bus.ihit); end
        tests++; if (bus.imemload !== 32'h4444_0040) begin fails++; $display("FAIL unaligned_0x40_data got=%h exp=44440040", bus.imemload); end
        @(posedge clk); #1;
        bus.imemREN = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_midfetch_addr_change();
        test_reset_midfetch();
        test_unaligned();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
